ej7_sweep_checker: RTL and testbench
====================================

Name: ej7_sweep_checker

Overview:
- Sequential stimulus sequencer and equivalence checker for the ej7 combinational stage.
- Upstream side: on command, it sweeps the 4-variable input vector {A,B,C,D} and the 3-variable vector {x,y,z} through every code.
- Downstream side: it compares each pair of alternative implementations (Y/Yb, Z/Zb, F2/F2b) and reports mismatch count, first failing vector and pass/done status.
- Replaces the open-loop for-loop stimulus with a synthesizable, self-checking block.

Parameters:
- K, 4, width of the first circuit's input vector (A,B,C,D).
- K2, 3, width of the second circuit's input vector (x,y,z); K2 <= K.
- HOLD, 2, number of cycles each vector is driven before sampling; must be >= 1.
- NPAIR, 3, number of output pairs compared (bit0=Y/Yb, bit1=Z/Zb, bit2=F2/F2b).

Ports:
- clk  in  1  single system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  sweep request, sampled in IDLE or DONE only.
- abcd  out  K  drives {A,B,C,D}; MSB = A.
- xyz  out  K2  drives {x,y,z}; MSB = x.
- dut_a  in  NPAIR  primary outputs {F2,Z,Y}.
- dut_b  in  NPAIR  alternative outputs {F2b,Zb,Yb}.
- busy  out  1  sweep in progress.
- done  out  1  sweep complete; held until next accepted start.
- pass  out  1  valid when done: 1 if no mismatch was found.
- err_count  out  K+1  number of sampled vectors with any mismatch.
- first_fail_vec  out  K  abcd value of the first mismatching vector.
- first_fail_mask  out  NPAIR  dut_a^dut_b captured at the first mismatch.

Behaviour:
- Reset low, asynchronous, immediate: state=IDLE. The following are all 0: abcd, xyz, busy, done, pass, err_count, first_fail_vec, first_fail_mask, hold counter and vector counter n. This applies mid-sweep as well: the sweep is abandoned with no partial done.
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE / DONE + start=1: at that edge (edge 0), clear err_count, first_fail_* and pass. Set n=0, hold counter=0, busy=1, done=0, go to DRIVE. start=0 stays in the current state.
- DRIVE: abcd=n; xyz=n[K2-1:0] while n <= 2^K2-1, otherwise xyz holds 2^K2-1. The hold counter increments each cycle. After HOLD cycles in DRIVE, go to SAMPLE.
- SAMPLE: one cycle with abcd/xyz unchanged. Compute m = dut_a ^ dut_b.
  - If m != 0: err_count += 1.
  - If m != 0 and this is the first mismatch: latch first_fail_vec=n and first_fail_mask=m.
  - Then, if n == 2^K-1: go to DONE, busy=0, done=1, pass=(final err_count==0). Otherwise n+=1, hold counter=0, go to DRIVE.
- Every code 0..2^K-1 is covered inclusively; the sweep never wraps.
- Each vector occupies HOLD+1 cycles. done rises after edge 2^K*(HOLD+1) counted from the start edge: edge 48 at defaults.
- err_count cannot exceed 2^K, so K+1 bits never overflow.
- start is ignored while busy. A start that coincides with the final SAMPLE edge is ignored; a start in DONE restarts the sweep.
- abcd/xyz hold their last values in DONE and return to 0 only on reset.
- pass is meaningful only when done=1; it is 0 otherwise.

Test Plan:
- Equivalent DUT (dut_b tied to dut_a = model of ej7), start pulse at edge 0 -> busy 1 through edge 47; done=1, pass=1, err_count=0 after edge 48; abcd=15, xyz=7 held.
- Fault injected so that dut_b[1] is inverted only when abcd==5 -> err_count=1, first_fail_vec=5, first_fail_mask=3'b010, pass=0.
- dut_b = ~dut_a constantly -> err_count=16, first_fail_vec=0, first_fail_mask=3'b111, pass=0.
- Stimulus check: xyz==abcd[2:0] for abcd 0..7; xyz==7 for abcd 8..15. Each abcd value is stable for exactly 3 cycles.
- start re-pulsed at edge 10 (ignored, done still at edge 48). Then reset low while abcd==6 -> all outputs 0 asynchronously. A new start after release gives a full clean sweep with identical results.
- HOLD=1 instance, equivalent DUT -> done after edge 32, pass=1.

Source files
------------

// File: rtl/ej7_sweep_checker.sv
// Sweeps {A,B,C,D} and {x,y,z} through every code and checks that each pair of
// alternative ej7 implementations agrees. Reports a mismatch count, the first failing vector and pass/done.
module ej7_sweep_checker #(
    parameter int K     = 4,
    parameter int K2    = 3,
    parameter int HOLD  = 2,
    parameter int NPAIR = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic [K-1:0]     abcd,
    output logic [K2-1:0]    xyz,
    input  logic [NPAIR-1:0] dut_a,
    input  logic [NPAIR-1:0] dut_b,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [K:0]       err_count,
    output logic [K-1:0]     first_fail_vec,
    output logic [NPAIR-1:0] first_fail_mask
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DRIVE  = 2'd1;
    localparam logic [1:0] SAMPLE = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    localparam int            HW    = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HW-1:0] HLAST = HW'(HOLD - 1);
    localparam logic [K-1:0]  NLAST = '1;

    logic [1:0]       state;
    logic [K-1:0]     n;
    logic [K-1:0]     n_nxt;
    logic [HW-1:0]    hcnt;
    logic [NPAIR-1:0] m;
    logic [K2-1:0]    xyz_nxt;

    assign m     = dut_a ^ dut_b;
    assign n_nxt = n + 1'b1;

    // xyz saturates at all-ones once n leaves the K2-bit range
    always_comb begin
        xyz_nxt = n_nxt[K2-1:0];
        if ((n_nxt >> K2) != '0) xyz_nxt = '1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            n               <= '0;
            hcnt            <= '0;
            abcd            <= '0;
            xyz             <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_fail_vec  <= '0;
            first_fail_mask <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        err_count       <= '0;
                        first_fail_vec  <= '0;
                        first_fail_mask <= '0;
                        pass            <= 1'b0;
                        n               <= '0;
                        hcnt            <= '0;
                        abcd            <= '0;
                        xyz             <= '0;
                        busy            <= 1'b1;
                        done            <= 1'b0;
                        state           <= DRIVE;
                    end
                end
                DRIVE: begin
                    hcnt <= hcnt + 1'b1;
                    if (hcnt == HLAST) state <= SAMPLE;
                end
                SAMPLE: begin
                    if (m != '0) begin
                        err_count <= err_count + 1'b1;
                        if (err_count == '0) begin
                            first_fail_vec  <= n;
                            first_fail_mask <= m;
                        end
                    end
                    if (n == NLAST) begin
                        // pass folds in this last sample, not just the registered count
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_count == '0) && (m == '0);
                    end else begin
                        n     <= n_nxt;
                        hcnt  <= '0;
                        abcd  <= n_nxt;
                        xyz   <= xyz_nxt;
                        state <= DRIVE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ej7_sweep_checker.sv
// Randomized fault-table sweeps against a loop-based reference model, with a
// scoreboard popped by a monitor whenever done rises.
module tb_ej7_sweep_checker;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start0 = 1'b0, start1 = 1'b0;
    logic [3:0] abcd0, abcd1;
    logic [2:0] xyz0, xyz1;
    logic [2:0] a0, b0, a1, b1;
    logic       busy0, done0, pass0, busy1, done1, pass1;
    logic [4:0] err0, err1;
    logic [3:0] ffv0, ffv1;
    logic [2:0] ffm0, ffm1;
    logic [2:0] fault [16];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int errs;
        int ffv;
        int ffm;
        int pass;
        int done_cyc;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // stand-in for the ej7 stage; dut_b is the same function with injected flips
    function automatic logic [2:0] ej7(input logic [3:0] v, input logic [2:0] w);
        return {^v ^ w[2], (v[3] & v[1]) | ~w[0], (v[0] ^ v[2]) & w[1]};
    endfunction

    assign a0 = ej7(abcd0, xyz0);
    assign b0 = a0 ^ fault[abcd0];
    assign a1 = ej7(abcd1, xyz1);
    assign b1 = a1;

    ej7_sweep_checker #(.K(4), .K2(3), .HOLD(2), .NPAIR(3)) u0 (
        .clk(clk), .reset(reset), .start(start0), .abcd(abcd0), .xyz(xyz0),
        .dut_a(a0), .dut_b(b0), .busy(busy0), .done(done0), .pass(pass0),
        .err_count(err0), .first_fail_vec(ffv0), .first_fail_mask(ffm0));

    ej7_sweep_checker #(.K(4), .K2(3), .HOLD(1), .NPAIR(3)) u1 (
        .clk(clk), .reset(reset), .start(start1), .abcd(abcd1), .xyz(xyz1),
        .dut_a(a1), .dut_b(b1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .first_fail_vec(ffv1), .first_fail_mask(ffm1));

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // reference: walk every code once, accumulate mismatches from the fault table
    function automatic exp_t model(input int start_edge, input int hold);
        exp_t e;
        e.errs = 0; e.ffv = 0; e.ffm = 0;
        for (int v = 0; v < 16; v++) begin
            if (fault[v] != 3'b000) begin
                if (e.errs == 0) begin
                    e.ffv = v;
                    e.ffm = int'(fault[v]);
                end
                e.errs++;
            end
        end
        e.pass = (e.errs == 0) ? 1 : 0;
        e.done_cyc = start_edge + 16 * (hold + 1);
        return e;
    endfunction

    task automatic start_sweep0();
        @(negedge clk);
        sb.push_back(model(cyc + 1, 2));
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
    endtask

    task automatic wait_done0(input int limit);
        int i;
        for (i = 0; i < limit; i++) begin
            @(negedge clk);
            if (done0) break;
        end
        if (i == limit) chk("done0_timeout", 0, 1);
    endtask

    task automatic set_faults(input int mode);
        for (int v = 0; v < 16; v++) begin
            case (mode)
                0: fault[v] = 3'b000;
                1: fault[v] = (v == 5) ? 3'b010 : 3'b000;
                2: fault[v] = 3'b111;
                default: fault[v] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            endcase
        end
    endtask

    // monitor: scoreboard pop on done rising, per-cycle stimulus-shape checks while busy
    initial begin
        exp_t e;
        logic done_q = 1'b0;
        logic inrun = 1'b0;
        logic [3:0] prev = 4'd0;
        int run = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                inrun = 1'b0;
            end else begin
                if (done0 && !done_q) begin
                    if (sb.size() == 0) chk("sb_unexpected_done", 1, 0);
                    else begin
                        e = sb.pop_front();
                        chk("err_count", int'(err0), e.errs);
                        chk("first_fail_vec", int'(ffv0), e.ffv);
                        chk("first_fail_mask", int'(ffm0), e.ffm);
                        chk("pass", int'(pass0), e.pass);
                        chk("done_edge", cyc, e.done_cyc);
                        chk("abcd_final", int'(abcd0), 15);
                        chk("xyz_final", int'(xyz0), 7);
                    end
                end
                if (busy0) begin
                    chk("pass_low_busy", int'(pass0), 0);
                    chk("done_low_busy", int'(done0), 0);
                    chk("xyz_map", int'(xyz0), (abcd0 < 4'd8) ? int'(abcd0[2:0]) : 7);
                    if (inrun && abcd0 == prev) run++;
                    else begin
                        if (inrun) begin
                            chk("hold_len", run, 3);
                            chk("abcd_step", int'(abcd0), int'(prev) + 1);
                        end
                        inrun = 1'b1;
                        run = 1;
                    end
                    prev = abcd0;
                end else if (inrun) begin
                    if (done0) chk("hold_len_last", run, 3);
                    inrun = 1'b0;
                end
            end
            done_q = done0;
        end
    end

    initial begin
        int s;
        int i;
        set_faults(0);
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy0), 0);
        chk("rst_done", int'(done0), 0);
        chk("rst_pass", int'(pass0), 0);
        chk("rst_err", int'(err0), 0);
        chk("rst_abcd", int'(abcd0), 0);
        chk("rst_xyz", int'(xyz0), 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_no_start", int'(busy0), 0);

        // equivalent sweep with a start re-pulse at edge 10 that must be ignored
        start_sweep0();
        s = cyc;
        while (cyc < s + 9) @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        chk("busy_mid", int'(busy0), 1);
        wait_done0(200);
        repeat (3) @(negedge clk);
        chk("done_held", int'(done0), 1);
        chk("abcd_held", int'(abcd0), 15);
        chk("xyz_held", int'(xyz0), 7);

        set_faults(1);
        start_sweep0();
        wait_done0(200);
        set_faults(2);
        start_sweep0();
        wait_done0(200);
        for (int r = 0; r < 6; r++) begin
            set_faults(3);
            start_sweep0();
            wait_done0(200);
        end

        // abandon a sweep with an asynchronous reset mid-vector
        set_faults(2);
        start_sweep0();
        for (i = 0; i < 100; i++) begin
            @(negedge clk);
            if (abcd0 == 4'd6) break;
        end
        if (i == 100) chk("abcd6_timeout", 0, 1);
        chk("err_before_rst", int'(err0), 6);
        #2 reset = 1'b0;
        #1;
        chk("arst_busy", int'(busy0), 0);
        chk("arst_done", int'(done0), 0);
        chk("arst_err", int'(err0), 0);
        chk("arst_ffv", int'(ffv0), 0);
        chk("arst_ffm", int'(ffm0), 0);
        chk("arst_abcd", int'(abcd0), 0);
        chk("arst_xyz", int'(xyz0), 0);
        void'(sb.pop_back());
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        chk("post_rst_idle", int'(busy0 | done0), 0);
        start_sweep0();
        wait_done0(200);

        // HOLD=1 instance, equivalent pair
        @(negedge clk);
        s = cyc + 1;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        for (i = 0; i < 100; i++) begin
            if (done1) break;
            @(negedge clk);
        end
        if (i == 100) chk("done1_timeout", 0, 1);
        chk("h1_done_edge", cyc, s + 32);
        chk("h1_pass", int'(pass1), 1);
        chk("h1_err", int'(err1), 0);
        chk("h1_abcd", int'(abcd1), 15);
        chk("h1_xyz", int'(xyz1), 7);

        repeat (2) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
